// File: rtl/pc_predict_unit_if.sv
// Fetch-side bundle of the PC predictor: control inputs,
// redirect/training ports from EX and the predicted fetch PC.
interface pc_predict_unit_if #(
  parameter int ADDR_W = 32
);
  logic              rdy;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_taken;
  logic [1:0]        upd_kind;
  logic [ADDR_W-1:0] pc;
  logic              pred_taken;

  modport master (
    output rdy, stall, redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken, upd_kind,
    input  pc, pred_taken
  );

  modport slave (
    input  rdy, stall, redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken, upd_kind,
    output pc, pred_taken
  );
endinterface

// File: rtl/pc_predict_unit.sv
// Fetch PC generator: direct-mapped tagged BTB with direction
// counters plus a speculative circular return address stack.
module pc_predict_unit #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 7,
  parameter int TAG_BITS   = 9,
  parameter int CTR_BITS   = 2,
  parameter int RAS_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  pc_predict_unit_if.slave bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CTR_BITS-1:0] CTR_WT =
    CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WN = CTR_WT - 1'b1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INDEX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;
  typedef enum logic [1:0] {
    K_COND = 2'b00,
    K_JUMP = 2'b01,
    K_CALL = 2'b10,
    K_RET  = 2'b11
  } kind_e;

  logic [ENTRIES-1:0]  valid_q;
  tag_t                tag_q  [ENTRIES];
  addr_t               tgt_q  [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q  [ENTRIES];
  kind_e               kind_q [ENTRIES];

  addr_t            ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  addr_t            pc_q, pc_d;

  function automatic logic [PTR_W-1:0] wrap_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] wrap_dec(
    input logic [PTR_W-1:0] p
  );
    return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - 1'b1;
  endfunction

  idx_t  idx;
  tag_t  tag;
  logic  hit;
  addr_t pc4;
  addr_t ras_top;
  addr_t pred_pc;
  logic  push, pop;

  assign idx     = pc_q[INDEX_BITS+1:2];
  assign tag     = pc_q[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign hit     = valid_q[idx] && (tag_q[idx] == tag);
  assign pc4     = pc_q + ADDR_W'(4);
  assign ras_top = ras_q[wrap_dec(ptr_q)];

  always_comb begin
    pred_pc = pc4;
    push    = 1'b0;
    pop     = 1'b0;
    if (hit) begin
      unique case (kind_q[idx])
        K_COND: if (ctr_q[idx][CTR_BITS-1]) pred_pc = tgt_q[idx];
        K_JUMP: pred_pc = tgt_q[idx];
        K_CALL: begin
          pred_pc = tgt_q[idx];
          push    = 1'b1;
        end
        K_RET: if (cnt_q != '0) begin
          pred_pc = ras_top;
          pop     = 1'b1;
        end
        default: pred_pc = pc4;
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pred_taken = (pred_pc != pc4);

  logic ras_we;

  always_comb begin
    pc_d   = pc_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ras_we = 1'b0;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc;
    end else if (!bus.stall) begin
      pc_d = pred_pc;
      if (push) begin
        ras_we = 1'b1;
        ptr_d  = wrap_inc(ptr_q);
        if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
      end else if (pop) begin
        ptr_d = wrap_dec(ptr_q);
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  idx_t                uidx;
  tag_t                utag;
  logic                uhit;
  kind_e               ukind;
  logic [CTR_BITS-1:0] ucur, ctr_new;
  logic                unused_upd;

  assign uidx  = bus.upd_pc[INDEX_BITS+1:2];
  assign utag  = bus.upd_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign uhit  = valid_q[uidx] && (tag_q[uidx] == utag);
  assign ukind = kind_e'(bus.upd_kind);
  assign ucur  = ctr_q[uidx];
  assign unused_upd = ^bus.upd_pc;

  always_comb begin
    ctr_new = ucur;
    if (ukind == K_COND) begin
      if (!uhit) begin
        ctr_new = bus.upd_taken ? CTR_WT : CTR_WN;
      end else if (bus.upd_taken) begin
        if (ucur != '1) ctr_new = ucur + 1'b1;
      end else begin
        if (ucur != '0) ctr_new = ucur - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else if (bus.rdy) begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (bus.upd_valid) valid_q[uidx] <= 1'b1;
    end
  end

  // Payload arrays need no reset: valid_q gates every use.
  always_ff @(posedge clk) begin
    if (rst && bus.rdy) begin
      if (ras_we) ras_q[ptr_q] <= pc4;
      if (bus.upd_valid) begin
        tag_q[uidx]  <= utag;
        tgt_q[uidx]  <= bus.upd_target;
        kind_q[uidx] <= ukind;
        ctr_q[uidx]  <= ctr_new;
      end
    end
  end

endmodule

// File: doc/pc_predict_unit.md
Name: pc_predict_unit

Overview:
- Parametrised fetch PC generator with an integrated branch predictor.
- Holds the fetch PC and a direct-mapped, tagged BTB whose entries carry a target, a saturating direction counter and a branch kind.
- Adds a speculative return address stack (RAS) for call/return prediction.
- Sits at the front of fetch. It is redirected by EX on mispredict and trained by EX on every resolved control-transfer instruction.

Parameters:
- ADDR_W, 32: PC/target width.
- INDEX_BITS, 7: BTB index width. Entries = 2^INDEX_BITS.
- TAG_BITS, 9: BTB tag width. Legal only if INDEX_BITS+TAG_BITS+2 <= ADDR_W.
- CTR_BITS, 2: direction counter width. Must be >= 1.
- RAS_DEPTH, 4: RAS entries. Must be >= 1.
- RESET_PC, 0: PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low. rst==0 at posedge resets.
- rdy  in  1  global ready. When 0, all state is frozen.
- stall  in  1  fetch stall. When 1, PC and RAS hold.
- redirect_valid  in  1  mispredict redirect from EX.
- redirect_pc  in  ADDR_W  correct next PC.
- upd_valid  in  1  train the BTB this cycle.
- upd_pc  in  ADDR_W  PC of the resolved instruction.
- upd_target  in  ADDR_W  resolved taken target. Ignored for kind 11.
- upd_taken  in  1  resolved direction.
- upd_kind  in  2  00 cond, 01 jump, 10 call, 11 ret.
- pc  out  ADDR_W  current fetch PC (registered).
- pred_taken  out  1  combinational: 1 if the next PC chosen for the current pc is not pc+4.

Behaviour:
- Address fields:
  - idx = pc[INDEX_BITS+1:2]
  - tag = pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]
  - hit = valid[idx] && tag match
  - pc+4 wraps modulo 2^ADDR_W.
- Next-PC prediction for the current pc (combinational):
  - miss → pc+4
  - cond → target if counter MSB==1, else pc+4
  - jump or call → target
  - ret → RAS top if RAS count>0, else pc+4
- Per-posedge priority: rst==0 > rdy==0 > redirect_valid > stall==0 > hold.
  - rst==0: pc<=RESET_PC; all valid bits cleared; RAS pointer and count <=0. Targets and counters are don't-care. Reset mid-operation discards all predictor state.
  - rdy==0: pc, RAS and BTB all hold. upd_valid is ignored.
  - redirect_valid: pc<=redirect_pc, even when stall==1. No RAS operation.
  - stall==0: pc<=predicted next PC. RAS is updated speculatively:
    - call hit: push pc+4.
    - ret hit with count>0: pop.
  - Otherwise pc holds.
- RAS:
  - Circular buffer.
  - Push when full overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty is a no-op.
  - RAS is not repaired on redirect.
- BTB training, when upd_valid && rdy && rst==1:
  - Write valid, tag, target and kind at upd_pc's index.
  - Counter on hit with kind cond: saturating increment if taken, saturating decrement if not. Saturates at 2^CTR_BITS-1 and at 0.
  - Counter on miss/replace with kind cond: init to 1000..0 (weak taken) if taken, else 0111..1 (weak not-taken).
  - Counter for non-cond kinds: unchanged or don't-care.
  - Training is independent of stall and redirect.
- Same-cycle update and lookup at the same index: lookup uses the pre-update contents. The write is visible from the next cycle.
- Latency:
  - Redirect reaches pc one cycle after the redirect_valid posedge.
  - A trained entry influences prediction from the cycle after the update.

Test Plan:
- Reset and sequential fetch: rst=0 for one cycle, then stall=0, no updates → pc = 0x0, 0x4, 0x8, 0xC; pred_taken=0 throughout.
- Direction counter:
  - One update pc=0x40, cond, taken, target 0x100 → counter=2; fetch reaching 0x40 goes next to 0x100 with pred_taken=1.
  - Two further not-taken updates → counter=0; 0x40 is followed by 0x44.
  - Four taken updates → counter saturates at 3.
- Tag aliasing: entry trained at 0x40 (idx 0x10, tag 0); redirect to 0x240 (idx 0x10, tag 1) → miss, next pc 0x244.
- RAS basic: call trained at 0x10 → 0x200; ret trained at 0x204 → fetch sequence 0x10, 0x200, 0x204, 0x14.
- RAS overflow (RAS_DEPTH=4): five nested calls → the first four rets return to the four most recent return addresses in LIFO order; the fifth ret finds the RAS empty and falls to pc+4.
- Priority and freeze:
  - stall=1 with redirect_valid=1, redirect_pc=0x80 → pc=0x80 next cycle.
  - rdy=0 with redirect and upd_valid asserted → pc unchanged and BTB unchanged.
  - rst=0 after training → previously predicted-taken PCs now go to pc+4.
